move_controller: RTL and testbench

- Upstream turn/move controller for the disappearing-mark tic-tac-toe game.
- Turns player button presses into a validated single-cycle `mark` pulse plus a `position`, and maintains `whosTurn` and `game_state`.
- Feeds Marker_and_Recorder, and reads back the recorder's grid outputs (y0..y8) and the win checker's result.
- Owns cursor navigation, occupancy checking, settle timing, the per-turn timeout and the game-over latch.

---
 rtl/game_pkg.sv | 26 ++
 rtl/button_edge_detect.sv | 14 +
 rtl/move_controller.sv | 140 ++++++++++++++
 tb/tb_move_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state/cell encodings and cursor navigation helper
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_OVER   = 2'b11
  } state_t;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_O = 2'b01;
  localparam logic [1:0] CELL_X = 2'b10;
  localparam int GRID_CELLS = 9;
  localparam logic [3:0] CURSOR_RESET = 4'd4;
  // Wrapping 3x3 move; only the highest-priority direction (up>down>left>right) applies
  function automatic logic [3:0] cursor_step(input logic [3:0] c, input logic up, input logic dn,
                                             input logic lf, input logic rt);
    logic [3:0] r, k;
    r = (c >= 4'd6) ? 4'd2 : (c >= 4'd3) ? 4'd1 : 4'd0;
    k = c - 4'd3 * r;
    if (up) r = (r == 4'd0) ? 4'd2 : r - 4'd1;
    else if (dn) r = (r == 4'd2) ? 4'd0 : r + 4'd1;
    else if (lf) k = (k == 4'd0) ? 4'd2 : k - 4'd1;
    else if (rt) k = (k == 4'd2) ? 4'd0 : k + 4'd1;
    return 4'd3 * r + k;
  endfunction
endpackage

// File: rtl/button_edge_detect.sv
// button_edge_detect: rising-edge pulses; history presets high so buttons held through reset do not fire
module button_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev_d, prev_q;
  always_comb prev_d = lvl;
  always_ff @(posedge clk) prev_q <= rst ? '1 : prev_d;
  assign rise = lvl & ~prev_q;
endmodule

// File: rtl/move_controller.sv
// move_controller: turn/cursor FSM issuing validated mark pulses, settle wait, turn timeout and game-over latch
module move_controller import game_pkg::*; #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       start,
  input  logic [1:0] x0,
  input  logic [1:0] x1,
  input  logic [1:0] x2,
  input  logic [1:0] x3,
  input  logic [1:0] x4,
  input  logic [1:0] x5,
  input  logic [1:0] x6,
  input  logic [1:0] x7,
  input  logic [1:0] x8,
  input  logic [1:0] winner,
  output logic [1:0] game_state,
  output logic       whosTurn,
  output logic [1:0] mark,
  output logic [3:0] position,
  output logic [3:0] cursor,
  output logic       invalid_move,
  output logic       timeout,
  output logic       board_clear,
  output logic [1:0] final_winner
);
  logic [5:0] e;
  logic [1:0] cells [GRID_CELLS];
  logic [1:0] cell_cur;
  state_t state_d, state_q;
  logic turn_d, turn_q, inv_d, inv_q, to_d, to_q, clr_d, clr_q;
  logic [1:0] mark_d, mark_q, fw_d, fw_q;
  logic [3:0] pos_d, pos_q, cur_d, cur_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  button_edge_detect #(.W(6)) u_edge (
    .clk (clk),
    .rst (rst),
    .lvl ({start, btn_confirm, btn_right, btn_left, btn_down, btn_up}),
    .rise(e)
  );

  assign cells = '{x0, x1, x2, x3, x4, x5, x6, x7, x8};
  assign cell_cur = cells[cur_q];

  // One counter serves as turn timer in PLAY and settle timer in SETTLE (mark cycle = 0)
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    mark_d  = CELL_EMPTY;
    pos_d   = pos_q;
    cur_d   = cur_q;
    inv_d   = 1'b0;
    to_d    = 1'b0;
    clr_d   = 1'b0;
    fw_d    = fw_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (e[5]) begin
        state_d = ST_PLAY;
        turn_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_PLAY: begin
        cnt_d = cnt_q + 1'b1;
        if (!e[4]) cur_d = cursor_step(cur_q, e[0], e[1], e[2], e[3]);
        if (e[4] && cell_cur == CELL_EMPTY) begin
          mark_d  = turn_q ? CELL_X : CELL_O;
          pos_d   = cur_q;
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (e[4]) inv_d = 1'b1;
        else if (TIMEOUT_CYCLES != 0 && cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          to_d   = 1'b1;
          turn_d = ~turn_q;
          cnt_d  = '0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_W'(SETTLE_CYCLES)) begin
          state_d = (winner != CELL_EMPTY) ? ST_OVER : ST_PLAY;
          fw_d    = winner;
          turn_d  = (winner != CELL_EMPTY) ? turn_q : ~turn_q;
          cnt_d   = '0;
        end
      end
      ST_OVER: if (e[5]) begin
        state_d = ST_IDLE;
        clr_d   = 1'b1;
        fw_d    = CELL_EMPTY;
        cur_d   = CURSOR_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      turn_q  <= 1'b0;
      mark_q  <= CELL_EMPTY;
      pos_q   <= 4'd0;
      cur_q   <= CURSOR_RESET;
      inv_q   <= 1'b0;
      to_q    <= 1'b0;
      clr_q   <= 1'b0;
      fw_q    <= CELL_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      mark_q  <= mark_d;
      pos_q   <= pos_d;
      cur_q   <= cur_d;
      inv_q   <= inv_d;
      to_q    <= to_d;
      clr_q   <= clr_d;
      fw_q    <= fw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign game_state   = state_q;
  assign whosTurn     = turn_q;
  assign mark         = mark_q;
  assign position     = pos_q;
  assign cursor       = cur_q;
  assign invalid_move = inv_q;
  assign timeout      = to_q;
  assign board_clear  = clr_q;
  assign final_winner = fw_q;
endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed checks of move_controller; second instance has a 10-cycle turn timeout
module tb_move_controller;
  localparam logic [5:0] UP = 6'd1, DN = 6'd2, LF = 6'd4, RT = 6'd8, CF = 6'd16, ST = 6'd32;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] b;
  logic [1:0] xg [9];
  logic [1:0] winner;
  logic [1:0] gs, mk, fw, gs_t, mk_t, fw_t;
  logic wt, inv, to, bc, wt_t, inv_t, to_t, bc_t;
  logic [3:0] pos, cur, pos_t, cur_t;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_controller dut (
    .clk(clk), .rst(rst),
    .btn_up(b[0]), .btn_down(b[1]), .btn_left(b[2]), .btn_right(b[3]), .btn_confirm(b[4]), .start(b[5]),
    .x0(xg[0]), .x1(xg[1]), .x2(xg[2]), .x3(xg[3]), .x4(xg[4]), .x5(xg[5]), .x6(xg[6]), .x7(xg[7]), .x8(xg[8]),
    .winner(winner), .game_state(gs), .whosTurn(wt), .mark(mk), .position(pos), .cursor(cur),
    .invalid_move(inv), .timeout(to), .board_clear(bc), .final_winner(fw)
  );

  move_controller #(.TIMEOUT_CYCLES(10)) dut_t (
    .clk(clk), .rst(rst),
    .btn_up(b[0]), .btn_down(b[1]), .btn_left(b[2]), .btn_right(b[3]), .btn_confirm(b[4]), .start(b[5]),
    .x0(xg[0]), .x1(xg[1]), .x2(xg[2]), .x3(xg[3]), .x4(xg[4]), .x5(xg[5]), .x6(xg[6]), .x7(xg[7]), .x8(xg[8]),
    .winner(winner), .game_state(gs_t), .whosTurn(wt_t), .mark(mk_t), .position(pos_t), .cursor(cur_t),
    .invalid_move(inv_t), .timeout(to_t), .board_clear(bc_t), .final_winner(fw_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] v);
    b = v;
    tick();
    b = 6'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    b = 6'd0;
    rst = 1'b1;
    winner = 2'b00;
    for (int i = 0; i < 9; i++) xg[i] = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_state", gs, 0);
    chk("rst_turn", wt, 0);
    chk("rst_mark", mk, 0);
    chk("rst_pos", pos, 0);
    chk("rst_cursor", cur, 4);
    chk("rst_fw", fw, 0);
    chk("rst_pulses", {inv, to, bc}, 0);
    press(CF);
    chk("idle_confirm_mark", mk, 0);
    chk("idle_confirm_state", gs, 0);
    tick();
    press(ST);
    chk("start_state", gs, 1);
    chk("start_turn", wt, 0);
    tick();
    press(CF);
    chk("move1_mark", mk, 1);
    chk("move1_pos", pos, 4);
    chk("move1_state", gs, 2);
    tick();
    chk("move1_mark_pulse", mk, 0);
    chk("settle1_state", gs, 2);
    tick();
    chk("settle2_state", gs, 2);
    tick();
    chk("back_play_state", gs, 1);
    chk("back_play_turn", wt, 1);
    press(UP);
    chk("cur_up_4", cur, 1);
    tick();
    press(LF);
    chk("cur_left_1", cur, 0);
    tick();
    press(UP);
    chk("cur_up_wrap", cur, 6);
    tick();
    press(LF);
    chk("cur_left_wrap", cur, 8);
    tick();
    press(UP | RT);
    chk("cur_up_right", cur, 5);
    tick();
    press(CF | DN);
    chk("conf_prio_mark", mk, 2);
    chk("conf_prio_pos", pos, 5);
    chk("conf_prio_cursor", cur, 5);
    tick();
    tick();
    tick();
    chk("move2_state", gs, 1);
    chk("move2_turn", wt, 0);
    xg[4] = 2'b10;
    press(LF);
    chk("cur_to_4", cur, 4);
    tick();
    press(CF);
    chk("invalid_pulse", inv, 1);
    chk("invalid_mark", mk, 0);
    chk("invalid_state", gs, 1);
    chk("invalid_turn", wt, 0);
    tick();
    chk("invalid_once", inv, 0);
    xg[4] = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    press(ST);
    chk("t_start_state", gs_t, 1);
    repeat (9) tick();
    chk("t_no_early_timeout", to_t, 0);
    tick();
    chk("t_timeout_pulse", to_t, 1);
    chk("t_timeout_turn", wt_t, 1);
    chk("t_timeout_state", gs_t, 1);
    chk("t_timeout_mark", mk_t, 0);
    tick();
    chk("t_timeout_once", to_t, 0);
    repeat (8) tick();
    press(CF);
    chk("t_expiry_mark", mk_t, 2);
    chk("t_expiry_no_timeout", to_t, 0);
    chk("t_expiry_state", gs_t, 2);
    tick();
    tick();
    tick();
    chk("w_play_state", gs, 1);
    chk("w_play_turn", wt, 1);
    press(RT);
    chk("w_cur", cur, 5);
    tick();
    press(CF);
    chk("w_mark", mk, 2);
    chk("w_pos", pos, 5);
    winner = 2'b10;
    tick();
    tick();
    tick();
    chk("over_state", gs, 3);
    chk("over_fw", fw, 2);
    winner = 2'b00;
    tick();
    chk("over_fw_hold", fw, 2);
    press(CF);
    chk("over_no_mark", mk, 0);
    chk("over_stay", gs, 3);
    tick();
    press(ST);
    chk("clear_state", gs, 0);
    chk("clear_pulse", bc, 1);
    chk("clear_fw", fw, 0);
    chk("clear_cursor", cur, 4);
    tick();
    chk("clear_once", bc, 0);
    press(ST);
    chk("r_start", gs, 1);
    tick();
    b = CF;
    tick();
    chk("r_mark", mk, 1);
    chk("r_settle", gs, 2);
    rst = 1'b1;
    tick();
    chk("r_state", gs, 0);
    chk("r_mark_clr", mk, 0);
    chk("r_pos", pos, 0);
    chk("r_cursor", cur, 4);
    chk("r_turn", wt, 0);
    rst = 1'b0;
    tick();
    b = CF | ST;
    tick();
    chk("r_start_after", gs, 1);
    b = CF;
    tick();
    tick();
    chk("r_held_no_mark", mk, 0);
    chk("r_held_state", gs, 1);
    b = 6'd0;
    tick();
    press(CF);
    chk("r_repress_mark", mk, 1);
    chk("r_repress_pos", pos, 4);
    chk("r_repress_state", gs, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
